cp0_unit: RTL and testbench

System coprocessor 0 for the 5-stage MIPS pipeline. It holds the SR, Cause, EPC and PRId registers and evaluates hardware interrupts and M-stage exceptions. It produces the IntReq and EPC signals that the next-PC logic consumes to redirect fetch to the handler, or back to EPC on eret. It sits beside the M stage and services mtc0/mfc0 and eret.

---
 rtl/cp0_unit.sv | 138 +++++++++++++
 tb/tb_cp0_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
// Module      : cp0_unit
// Description : MIPS system coprocessor 0 (SR, Cause, EPC, PRId). Detects
//               hardware interrupts and M-stage exceptions with zero latency,
//               raises IntReq for the next-PC logic and services mtc0/mfc0
//               and eret (EXLClr).
//               Optional macro CP0_EPC_FWD_EN: forwards an mtc0 EPC write
//               to the EPC output in the same cycle as eret.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_unit #(
  parameter logic [31:0] PRID_VAL = 32'h0000_2018,
  parameter int          HWINT_W  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         A,
  input  logic [31:0]        DIn,
  input  logic               WE,
  input  logic [31:0]        PC_M,
  input  logic               BD_M,
  input  logic [4:0]         ExcCode_M,
  input  logic [HWINT_W-1:0] HWInt,
  input  logic               EXLClr,
  output logic [31:0]        DOut,
  output logic               IntReq,
  output logic [31:0]        EPC
);

  localparam logic [4:0]  c_addr_sr    = 5'd12;
  localparam logic [4:0]  c_addr_cause = 5'd13;
  localparam logic [4:0]  c_addr_epc   = 5'd14;
  localparam logic [4:0]  c_addr_prid  = 5'd15;
  localparam logic [31:0] c_word_mask  = ~32'h3;

  // Architectural state
  logic [HWINT_W-1:0] r_im;
  logic               r_exl;
  logic               r_ie;
  logic               r_bd;
  logic [HWINT_W-1:0] r_ip;
  logic [4:0]         r_exc_code;
  logic [31:0]        r_epc;

  logic               w_int_hit;
  logic               w_exc_hit;
  logic [31:0]        w_epc_entry;
  logic [31:0]        w_sr;
  logic [31:0]        w_cause;
  logic               w_wr_sr;
  logic               w_wr_epc;

  // Interrupt/exception detection; EXL blocks nested entry
  always_comb begin
    w_int_hit   = r_ie & ~r_exl & (|(HWInt & r_im));
    w_exc_hit   = ~r_exl & (ExcCode_M != 5'd0);
    IntReq      = w_int_hit | w_exc_hit;
    // Delay-slot instructions restart at the branch so it is re-executed
    w_epc_entry = (BD_M ? (PC_M - 32'd4) : PC_M) & c_word_mask;
    w_wr_sr     = WE & (A == c_addr_sr);
    w_wr_epc    = WE & (A == c_addr_epc);
  end

  // Assemble readable register images from their fields
  always_comb begin
    w_sr                    = 32'd0;
    w_sr[10 +: HWINT_W]     = r_im;
    w_sr[1]                 = r_exl;
    w_sr[0]                 = r_ie;
    w_cause                 = 32'd0;
    w_cause[31]             = r_bd;
    w_cause[10 +: HWINT_W]  = r_ip;
    w_cause[6:2]            = r_exc_code;
  end

  // mfc0 read mux; unmapped addresses read zero
  always_comb begin
    DOut = 32'd0;
    case (A)
      c_addr_sr:    DOut = w_sr;
      c_addr_cause: DOut = w_cause;
      c_addr_epc:   DOut = r_epc;
      c_addr_prid:  DOut = PRID_VAL;
      default:      DOut = 32'd0;
    endcase
  end

  // EPC output toward the next-PC logic
`ifdef CP0_EPC_FWD_EN
  always_comb begin
    EPC = r_epc;
    if (w_wr_epc && EXLClr) begin
      EPC = DIn & c_word_mask;
    end
  end
`else
  always_comb begin
    EPC = r_epc;
  end
`endif

  // Register update: exception entry overrides any concurrent mtc0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= 5'd0;
      r_epc      <= 32'd0;
    end else begin
      r_ip <= HWInt;
      if (IntReq) begin
        r_exl      <= 1'b1;
        r_bd       <= BD_M;
        r_exc_code <= w_int_hit ? 5'd0 : ExcCode_M;
        r_epc      <= w_epc_entry;
      end else begin
        if (w_wr_sr) begin
          r_im  <= DIn[10 +: HWINT_W];
          r_exl <= DIn[1];
          r_ie  <= DIn[0];
        end
        // eret takes precedence over an SR write for the EXL bit
        if (EXLClr) begin
          r_exl <= 1'b0;
        end
        if (w_wr_epc) begin
          r_epc <= DIn & c_word_mask;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_unit
// Description : Directed self-checking bench for cp0_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  A;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC_M;
  logic        BD_M;
  logic [4:0]  ExcCode_M;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] DOut;
  logic        IntReq;
  logic [31:0] EPC;

  int n_cmp = 0;
  int n_err = 0;

  cp0_unit dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .DIn       (DIn),
    .WE        (WE),
    .PC_M      (PC_M),
    .BD_M      (BD_M),
    .ExcCode_M (ExcCode_M),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .DOut      (DOut),
    .IntReq    (IntReq),
    .EPC       (EPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs settle 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    A = addr;
    #1;
    check_val(tag, DOut, exp);
  endtask

  initial begin
    reset = 1'b0; A = 5'd0; DIn = 32'd0; WE = 1'b0; PC_M = 32'd0;
    BD_M = 1'b0; ExcCode_M = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    #12;
    // Reset state
    rd("rst_sr",    5'd12, 32'h0000_0000);
    rd("rst_cause", 5'd13, 32'h0000_0000);
    rd("rst_epc",   5'd14, 32'h0000_0000);
    rd("rst_prid",  5'd15, 32'h0000_2018);
    rd("rst_unmap", 5'd5,  32'h0000_0000);
    check_val("rst_intreq", {31'd0, IntReq}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // mtc0 SR enabling IE and IM[0] with HWInt[0] pending
    WE = 1'b1; A = 5'd12; DIn = 32'h0000_0401; HWInt = 6'b000001;
    PC_M = 32'h0000_3010; BD_M = 1'b0;
    #1;
    check_val("sr_wr_intreq_pre", {31'd0, IntReq}, 32'd0);
    step();
    WE = 1'b0;
    #1;
    check_val("int_intreq", {31'd0, IntReq}, 32'd1);
    rd("int_sr_pre", 5'd12, 32'h0000_0401);
    step();
    check_val("int_epc", EPC, 32'h0000_3010);
    rd("int_sr", 5'd12, 32'h0000_0403);
    rd("int_cause", 5'd13, 32'h0000_0400);
    check_val("int_blocked", {31'd0, IntReq}, 32'd0);

    // eret, then exception in a delay slot
    HWInt = 6'd0; EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    rd("eret_sr", 5'd12, 32'h0000_0401);
    ExcCode_M = 5'd4; PC_M = 32'h0000_3024; BD_M = 1'b1;
    #1;
    check_val("exc_intreq", {31'd0, IntReq}, 32'd1);
    step();
    ExcCode_M = 5'd0; BD_M = 1'b0;
    #1;
    check_val("exc_epc", EPC, 32'h0000_3020);
    rd("exc_cause", 5'd13, 32'h8000_0010);

    // Interrupt and exception together; concurrent mtc0 EPC dropped
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    HWInt = 6'b000001; ExcCode_M = 5'd10; PC_M = 32'h0000_3100;
    WE = 1'b1; A = 5'd14; DIn = 32'h0000_1234;
    #1;
    check_val("prio_intreq", {31'd0, IntReq}, 32'd1);
    step();
    WE = 1'b0; ExcCode_M = 5'd0;
    #1;
    check_val("prio_epc", EPC, 32'h0000_3100);
    rd("prio_cause", 5'd13, 32'h0000_0400);

    // eret with interrupt still pending: re-entry the cycle after
    EXLClr = 1'b1;
    #1;
    check_val("eret_intreq_same", {31'd0, IntReq}, 32'd0);
    step();
    EXLClr = 1'b0;
    rd("eret2_sr", 5'd12, 32'h0000_0401);
    check_val("reentry_intreq", {31'd0, IntReq}, 32'd1);
    step();
    HWInt = 6'd0;

    // mtc0 EPC together with eret
    WE = 1'b1; A = 5'd14; DIn = 32'h0000_3047; EXLClr = 1'b1;
    #1;
`ifdef CP0_EPC_FWD_EN
    check_val("fwd_epc_same", EPC, 32'h0000_3044);
`else
    check_val("fwd_epc_same", EPC, 32'h0000_3100);
`endif
    step();
    WE = 1'b0; EXLClr = 1'b0;
    #1;
    check_val("fwd_epc_next", EPC, 32'h0000_3044);
    rd("fwd_epc_rd", 5'd14, 32'h0000_3044);

    // SR write with EXL=1 and simultaneous eret: EXL stays cleared
    WE = 1'b1; A = 5'd12; DIn = 32'h0000_0403; EXLClr = 1'b1;
    step();
    WE = 1'b0; EXLClr = 1'b0;
    rd("sr_exlclr_wins", 5'd12, 32'h0000_0401);

    // Writes to Cause are ignored
    WE = 1'b1; A = 5'd13; DIn = 32'hFFFF_FFFF;
    step();
    WE = 1'b0;
    rd("cause_ro", 5'd13, 32'h0000_0000);

    // Delay-slot exception at PC 0 wraps
    ExcCode_M = 5'd1; PC_M = 32'h0000_0000; BD_M = 1'b1;
    step();
    ExcCode_M = 5'd0; BD_M = 1'b0;
    #1;
    check_val("wrap_epc", EPC, 32'hFFFF_FFFC);

    // Asynchronous reset mid-operation with interrupt line held
    HWInt = 6'b000001;
    #2;
    reset = 1'b0;
    #1;
    rd("mid_rst_sr", 5'd12, 32'h0000_0000);
    check_val("mid_rst_epc", EPC, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b1;
    step();
    check_val("mid_rst_intreq", {31'd0, IntReq}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
